// File: rtl/timer_arbiter.sv
// timer_arbiter: time-shares one interval counter among NUM_REQ requesters.
// Optional: define TIMER_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration.
module timer_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int NUM_BITS        = 4,
  parameter int TICKS_PER_GRANT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_period,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic [NUM_REQ-1:0]           tick,
  output logic [NUM_REQ-1:0]           done,
  output logic [NUM_BITS-1:0]          count_out
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TICKS_PER_GRANT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [IW-1:0]       rr_q;
  logic [IW-1:0]       own_q;
  logic [IW-1:0]       win_idx;
  logic [IW-1:0]       rr_nxt;
  logic [NUM_REQ-1:0]  win_oh;
  logic [NUM_BITS-1:0] per_q;
  logic [NUM_BITS-1:0] win_per;
  logic [NUM_BITS-1:0] cnt_nxt;
  logic [TW-1:0]       tcnt_q;
  logic                last_tick;

  // Scan from the rr pointer; in fixed mode it stays 0, giving lowest-index.
  always_comb begin
    logic [IW:0] j;
    logic [IW-1:0] k;
    logic found;
    j = '0;
    k = '0;
    found = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = {1'b0, rr_q} + (IW+1)'(i);
      if (j >= (IW+1)'(NUM_REQ)) j = j - (IW+1)'(NUM_REQ);
      k = j[IW-1:0];
      if (!found && req[k]) begin
        found = 1'b1;
        win_idx = k;
      end
    end
  end

  always_comb begin
    win_oh  = NUM_REQ'(1) << win_idx;
    win_per = req_period[win_idx*NUM_BITS +: NUM_BITS];
`ifdef TIMER_ARB_FIXED_PRIORITY_EN
    rr_nxt  = '0;
`else
    rr_nxt  = (win_idx == IW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
`endif
    cnt_nxt   = (count_out == per_q) ? NUM_BITS'(1) : count_out + 1'b1;
    last_tick = (tick != '0) && (tcnt_q == TW'(TICKS_PER_GRANT-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      busy      <= 1'b0;
      tick      <= '0;
      done      <= '0;
      count_out <= '0;
      rr_q      <= '0;
      own_q     <= '0;
      per_q     <= '0;
      tcnt_q    <= '0;
    end else begin
      tick <= '0;
      done <= '0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            state     <= RUN;
            grant     <= win_oh;
            busy      <= 1'b1;
            count_out <= '0;
            own_q     <= win_idx;
            rr_q      <= rr_nxt;
            tcnt_q    <= '0;
            per_q     <= (win_per == '0) ? NUM_BITS'(1) : win_per;
          end
        end
        RUN: begin
          // Abort beats a coincident final tick.
          if (!req[own_q]) begin
            state     <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            count_out <= '0;
          end else if (last_tick) begin
            state     <= DONE;
            done      <= grant;
            grant     <= '0;
            busy      <= 1'b0;
            count_out <= '0;
          end else begin
            if (tick != '0) tcnt_q <= tcnt_q + 1'b1;
            count_out <= cnt_nxt;
            if (cnt_nxt == per_q) tick <= grant;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: randomized rounds against a cycle-trace scoreboard.
// Expected traces come from closed-form per-grant arithmetic.
module tb_timer_arbiter;

  localparam int NR  = 4;
  localparam int NB  = 4;
  localparam int TPG = 2;

  logic              tb_clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*NB-1:0]  req_period;
  logic [NR-1:0]     grant;
  logic              busy;
  logic [NR-1:0]     tick;
  logic [NR-1:0]     done;
  logic [NB-1:0]     count_out;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int rr_m   = 0;

  typedef struct {
    int            cyc;
    logic [NR-1:0] grant;
    logic [NR-1:0] tick;
    logic [NR-1:0] done;
    logic          busy;
    logic [NB-1:0] count;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;

  timer_arbiter #(
    .NUM_REQ(NR),
    .NUM_BITS(NB),
    .TICKS_PER_GRANT(TPG)
  ) dut (
    .clk(tb_clk),
    .rst(rst),
    .req(req),
    .req_period(req_period),
    .grant(grant),
    .busy(busy),
    .tick(tick),
    .done(done),
    .count_out(count_out)
  );

  always #5 tb_clk = ~tb_clk;

  always @(posedge tb_clk) cyc <= cyc + 1;

  function automatic void push(input int c, input logic [NR-1:0] g,
                               input logic [NR-1:0] t, input logic [NR-1:0] d,
                               input logic b, input logic [NB-1:0] cnt);
    exp_t e;
    e.cyc = c;
    e.grant = g;
    e.tick = t;
    e.done = d;
    e.busy = b;
    e.count = cnt;
    sb.push_back(e);
  endfunction

  // Monitor: compare whenever an expected entry falls due.
  always @(negedge tb_clk) begin
    if (sb.size() > 0) begin
      if (sb[0].cyc < cyc) begin
        m_e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missed cyc=%0d now=%0d", m_e.cyc, cyc);
      end else if (sb[0].cyc == cyc) begin
        m_e = sb.pop_front();
        checks++;
        if ({grant, busy, tick, done, count_out} !==
            {m_e.grant, m_e.busy, m_e.tick, m_e.done, m_e.count}) begin
          errors++;
          $display("FAIL trace cyc=%0d got g=%b b=%b t=%b d=%b c=%0d exp g=%b b=%b t=%b d=%b c=%0d",
                   cyc, grant, busy, tick, done, count_out,
                   m_e.grant, m_e.busy, m_e.tick, m_e.done, m_e.count);
        end
      end
    end
  end

  // kind: 0 full grant, 1 abort in RUN cycle a, 2 reset in RUN cycle a.
  task automatic run_round(input logic [NR-1:0] r, input logic [NR*NB-1:0] pers,
                           input int kind, input int a);
    int c0, w, p, L, stop, k;
    logic [NR-1:0] oh;
    c0 = cyc;
    rst = 1'b0;
    req = r;
    req_period = pers;
    if (r == '0) begin
      push(c0 + 1, '0, '0, '0, 1'b0, '0);
      @(negedge tb_clk);
      return;
    end
    w = -1;
    for (int i = 0; i < NR; i++) begin
`ifdef TIMER_ARB_FIXED_PRIORITY_EN
      k = i;
`else
      k = (rr_m + i) % NR;
`endif
      if (w < 0 && r[k]) w = k;
    end
`ifndef TIMER_ARB_FIXED_PRIORITY_EN
    rr_m = (w + 1) % NR;
`endif
    oh = NR'(1) << w;
    p = int'(pers[w*NB +: NB]);
    if (p == 0) p = 1;
    L = TPG * p + 1;
    if (kind == 0) stop = L;
    else stop = (a < 1) ? 1 : ((a > L) ? L : a);
    for (int n = 1; n <= stop; n++)
      push(c0 + n, oh, (n >= 2 && (n - 1) % p == 0) ? oh : '0, '0, 1'b1,
           (n == 1) ? '0 : NB'((n - 2) % p + 1));
    if (kind == 0) begin
      push(c0 + L + 1, '0, '0, oh, 1'b0, '0);
      push(c0 + L + 2, '0, '0, '0, 1'b0, '0);
    end else begin
      push(c0 + stop + 1, '0, '0, '0, 1'b0, '0);
      if (kind == 2) rr_m = 0;
    end
    for (int n = 1; n <= stop; n++) begin
      @(negedge tb_clk);
      req = (NR'($urandom) & ~oh) | oh;
      req_period = (NR*NB)'($urandom);
      if (n == stop && kind == 1) req = req & ~oh;
      if (n == stop && kind == 2) rst = 1'b1;
    end
    @(negedge tb_clk);
    if (kind == 0) @(negedge tb_clk);
    rst = 1'b0;
  endtask

  initial begin
    int kd, kk;
    rst = 1'b1;
    req = 4'b1111;
    req_period = 16'h1234;
    repeat (2) begin
      @(negedge tb_clk);
      checks++;
      if ({grant, busy, tick, done, count_out} !== '0) begin
        errors++;
        $display("FAIL reset got g=%b b=%b t=%b d=%b c=%0d exp all 0",
                 grant, busy, tick, done, count_out);
      end
    end

    run_round(4'b0001, 16'h0003, 0, 0);
    run_round(4'b0010, 16'h0050, 1, 3);
    run_round(4'b1000, 16'h0000, 0, 0);
    run_round(4'b0100, 16'h0700, 2, 2);
    repeat (3) run_round(4'b0101, 16'h1111, 0, 0);
    run_round(4'b0100, 16'h0300, 2, 3);
    run_round(4'b1111, 16'h2222, 0, 0);
    run_round(4'b0001, 16'h000F, 1, 31);

    for (int i = 0; i < 60; i++) begin
      kk = int'($urandom_range(0, 7));
      kd = (kk < 5) ? 0 : ((kk < 7) ? 1 : 2);
      run_round(NR'($urandom_range(0, 15)), (NR*NB)'($urandom), kd,
                int'($urandom_range(1, 31)));
    end

    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge tb_clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
